// File: rtl/fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// arbitrary depth, and a selectable standard or first-word-fall-through read port.
module fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  input  logic                                rd_en,
  input  logic [FIFO_WIDTH-1:0]               data_in,
  output logic [FIFO_WIDTH-1:0]               data_out,
  output logic                                wr_ack,
  output logic                                overflow,
  output logic                                underflow,
  output logic                                full,
  output logic                                empty,
  output logic                                almostfull,
  output logic                                almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     data_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;

  logic wr_acc;
  logic rd_acc;

  // Explicit wrap so non-power-of-two depths never index past the last word.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  assign full        = (count_q == CNT_FULL);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CNT_AF) && !full;
  assign almostempty = (count_q <= CNT_AE) && !empty;
  assign data_count  = count_q;

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // In FWFT mode the head word is visible directly; when empty, the last
  // popped word (cleared by reset) is shown instead of stale memory.
  assign data_out = ((FWFT != 0) && !empty) ? mem_q[rd_ptr_q] : data_q;

  always_comb begin
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_acc);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_d      = data_q;
    wr_ack_d    = wr_acc;
    overflow_d  = wr_en && !wr_acc;
    underflow_d = rd_en && !rd_acc;

    if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_acc) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      data_d   = mem_q[rd_ptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      data_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      data_q      <= data_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_fifo_prog.sv
// Directed bench for fifo_prog: default instance driven from a vector table,
// plus a depth-6 wrap stream, an FWFT instance and a mid-cycle reset sequence.
module tb_fifo_prog;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (depth 8, AF 7, AE 1, standard read)
  logic        wr_a = 0, rd_a = 0;
  logic [15:0] din_a = '0, dout_a;
  logic        ack_a, ovf_a, udf_a, full_a, empty_a, af_a, ae_a;
  logic [3:0]  cnt_a;

  // Instance B: depth 6, AF 4, AE 2
  logic        wr_b = 0, rd_b = 0;
  logic [15:0] din_b = '0, dout_b;
  logic        ack_b, ovf_b, udf_b, full_b, empty_b, af_b, ae_b;
  logic [2:0]  cnt_b;

  // Instance C: FWFT
  logic        wr_c = 0, rd_c = 0;
  logic [15:0] din_c = '0, dout_c;
  logic        ack_c, ovf_c, udf_c, full_c, empty_c, af_c, ae_c;
  logic [3:0]  cnt_c;

  fifo_prog u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_a), .rd_en(rd_a), .data_in(din_a),
    .data_out(dout_a), .wr_ack(ack_a), .overflow(ovf_a), .underflow(udf_a),
    .full(full_a), .empty(empty_a), .almostfull(af_a), .almostempty(ae_a),
    .data_count(cnt_a)
  );

  fifo_prog #(.FIFO_DEPTH(6), .AF_LEVEL(4), .AE_LEVEL(2)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_b), .rd_en(rd_b), .data_in(din_b),
    .data_out(dout_b), .wr_ack(ack_b), .overflow(ovf_b), .underflow(udf_b),
    .full(full_b), .empty(empty_b), .almostfull(af_b), .almostempty(ae_b),
    .data_count(cnt_b)
  );

  fifo_prog #(.FWFT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_c), .rd_en(rd_c), .data_in(din_c),
    .data_out(dout_c), .wr_ack(ack_c), .overflow(ovf_c), .underflow(udf_c),
    .full(full_c), .empty(empty_c), .almostfull(af_c), .almostempty(ae_c),
    .data_count(cnt_c)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic        ack;
    logic        ovf;
    logic        udf;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic wr, input logic rd, input logic [15:0] din,
                              input logic [3:0] cnt, input logic ack, input logic ovf,
                              input logic udf, input logic [15:0] dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
    v.ack = ack; v.ovf = ovf; v.udf = udf; v.dout = dout;
    vecs.push_back(v);
  endfunction

  // Expected status word for instance A: {ack,ovf,udf,full,empty,af,ae,cnt,dout}
  function automatic logic [63:0] exp_a(input vec_t v);
    logic f, e, af, ae;
    f  = (v.cnt == 4'd8);
    e  = (v.cnt == 4'd0);
    af = (v.cnt >= 4'd7) && !f;
    ae = (v.cnt <= 4'd1) && !e;
    return 64'({v.ack, v.ovf, v.udf, f, e, af, ae, v.cnt, v.dout});
  endfunction

  initial begin
    logic [15:0] q[$];
    logic [15:0] exp_d;
    logic [6:0]  af_mask, ae_mask;
    int sent, got, c, n;
    logic racc, wacc;

    // Fill / overflow / drain
    for (int k = 1; k <= 8; k++) add(1, 0, 16'(k), 4'(k), 1, 0, 0, 16'h0);
    add(1, 0, 16'hBEEF, 8, 0, 1, 0, 16'h0);
    add(0, 0, 16'h0,    8, 0, 0, 0, 16'h0);
    for (int k = 1; k <= 8; k++) add(0, 1, 16'h0, 4'(8 - k), 0, 0, 0, 16'(k));
    // Underflow cases on empty
    add(1, 1, 16'h1234, 1, 1, 0, 1, 16'h0008);
    add(0, 1, 16'h0,    0, 0, 0, 0, 16'h1234);
    add(0, 1, 16'h0,    0, 0, 0, 1, 16'h1234);
    // Refill, then simultaneous read/write while full, then drain
    for (int k = 0; k < 8; k++) add(1, 0, 16'(16'h10 + k), 4'(k + 1), 1, 0, 0, 16'h1234);
    add(1, 1, 16'h0099, 8, 1, 0, 0, 16'h0010);
    for (int k = 1; k <= 7; k++) add(0, 1, 16'h0, 4'(8 - k), 0, 0, 0, 16'(16'h10 + k));
    add(0, 1, 16'h0, 0, 0, 0, 0, 16'h0099);

    // Reset held across clock edges
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", 64'({full_a, empty_a, af_a, ae_a, cnt_a, ack_a, ovf_a, udf_a, dout_a}),
          64'({1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0}));
    check("reset_b", 64'({full_b, empty_b, af_b, ae_b, cnt_b}), 64'({1'b0, 1'b1, 1'b0, 1'b0, 3'd0}));
    check("reset_c", 64'({empty_c, cnt_c, dout_c}), 64'({1'b1, 4'd0, 16'h0}));
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven sequence on instance A
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      wr_a = vecs[i].wr; rd_a = vecs[i].rd; din_a = vecs[i].din;
      @(posedge clk);
      #1;
      check($sformatf("vec_a[%0d]", i),
            64'({ack_a, ovf_a, udf_a, full_a, empty_a, af_a, ae_a, cnt_a, dout_a}),
            exp_a(vecs[i]));
    end
    @(negedge clk);
    wr_a = 0; rd_a = 0;

    // Depth-6 stream across pointer wrap, checked against a queue model
    sent = 0; got = 0; c = 0;
    af_mask = '0; ae_mask = '0;
    while (got < 20 && c < 300) begin
      @(negedge clk);
      wr_b  = (sent < 20) && (c % 4 != 3);
      rd_b  = (c >= 5) && (c % 2 == 1);
      din_b = 16'(16'h100 + sent);
      racc  = rd_b && (q.size() > 0);
      wacc  = wr_b && ((q.size() < 6) || racc);
      exp_d = '0;
      if (racc) exp_d = q.pop_front();
      if (wacc) begin
        q.push_back(din_b);
        sent++;
      end
      @(posedge clk);
      #1;
      n = q.size();
      check($sformatf("stream_flags[%0d]", c),
            64'({full_b, empty_b, af_b, ae_b, cnt_b}),
            64'({n == 6, n == 0, (n >= 4) && (n != 6), (n <= 2) && (n != 0), 3'(n)}));
      if (racc) begin
        check($sformatf("stream_data[%0d]", got), 64'(dout_b), 64'(exp_d));
        got++;
      end
      if (af_b) af_mask[cnt_b] = 1'b1;
      if (ae_b) ae_mask[cnt_b] = 1'b1;
      c++;
    end
    @(negedge clk);
    wr_b = 0; rd_b = 0;
    check("stream_words_out", 64'(got), 64'd20);
    check("stream_af_counts", 64'(af_mask), 64'(7'b0110000));
    check("stream_ae_counts", 64'(ae_mask), 64'(7'b0000110));

    // FWFT: head word visible without a read
    wr_c = 1; din_c = 16'h00A5;
    @(posedge clk); #1;
    check("fwft_fall_through", 64'({empty_c, dout_c}), 64'({1'b0, 16'h00A5}));
    @(negedge clk); wr_c = 0;
    @(posedge clk); #1;
    check("fwft_hold", 64'({cnt_c, dout_c}), 64'({4'd1, 16'h00A5}));
    @(negedge clk); rd_c = 1;
    @(posedge clk); #1;
    check("fwft_pop_empty", 64'({empty_c, cnt_c, udf_c}), 64'({1'b1, 4'd0, 1'b0}));
    @(negedge clk); rd_c = 0; wr_c = 1; din_c = 16'h0011;
    @(negedge clk); din_c = 16'h0022;
    @(negedge clk); wr_c = 0;
    @(posedge clk); #1;
    check("fwft_head_two", 64'({cnt_c, dout_c}), 64'({4'd2, 16'h0011}));
    @(negedge clk); rd_c = 1;
    @(posedge clk); #1;
    check("fwft_next_head", 64'({cnt_c, dout_c}), 64'({4'd1, 16'h0022}));
    @(negedge clk); rd_c = 0;

    // Mid-cycle reset at count 5 on instance A
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      wr_a = 1; din_a = 16'(16'h21 + k);
    end
    @(posedge clk); #1;
    check("pre_reset_count", 64'({cnt_a, ack_a}), 64'({4'd5, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_a",
          64'({full_a, empty_a, af_a, ae_a, cnt_a, ack_a, ovf_a, udf_a, dout_a}),
          64'({1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0}));
    @(posedge clk); #1;
    check("reset_held_a", 64'({empty_a, cnt_a, ack_a}), 64'({1'b1, 4'd0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1; wr_a = 1; din_a = 16'h5A5A;
    @(posedge clk); #1;
    check("post_reset_write", 64'({cnt_a, ack_a, empty_a}), 64'({4'd1, 1'b1, 1'b0}));
    @(negedge clk); wr_a = 0; rd_a = 1;
    @(posedge clk); #1;
    check("post_reset_read", 64'({cnt_a, dout_a, udf_a}), 64'({4'd0, 16'h5A5A, 1'b0}));
    @(negedge clk); rd_a = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_prog.md
FIFO_PROG -- requirements
Module: fifo_prog

Interface
REQ-001 Parameter FIFO_WIDTH, default 16: data word width in bits, minimum 1.
REQ-002 Parameter FIFO_DEPTH, default 8: number of storage words, minimum 2; non-power-of-two values are legal.
REQ-003 Parameter AF_LEVEL, default FIFO_DEPTH-1: almostfull threshold in words, legal range 1..FIFO_DEPTH-1.
REQ-004 Parameter AE_LEVEL, default 1: almostempty threshold in words, legal range 1..FIFO_DEPTH-1.
REQ-005 Parameter FWFT, default 0: 0 selects standard read mode, 1 selects first-word-fall-through mode.
REQ-006 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port wr_en, input, 1 bit: write request.
REQ-009 Port rd_en, input, 1 bit: read request.
REQ-010 Port data_in, input, FIFO_WIDTH bits: write data.
REQ-011 Port data_out, output, FIFO_WIDTH bits: read data.
REQ-012 Port wr_ack, output, 1 bit: registered, high for one cycle after an accepted write.
REQ-013 Port overflow, output, 1 bit: registered, high for one cycle after a write rejected because the FIFO was full.
REQ-014 Port underflow, output, 1 bit: registered, high for one cycle after a read rejected because the FIFO was empty.
REQ-015 Ports full, empty, almostfull, almostempty, output, 1 bit each: combinational status decoded from count.
REQ-016 Port data_count, output, $clog2(FIFO_DEPTH+1) bits: current occupancy, range 0..FIFO_DEPTH.

Function
REQ-017 A write is accepted when wr_en=1 and either count<FIFO_DEPTH, or count=FIFO_DEPTH with an accepted read in the same cycle.
- Accepted write: data_in stored at wr_ptr; wr_ptr advances.
REQ-018 A read is accepted when rd_en=1 and count>0.
- Accepted read: rd_ptr advances.
REQ-019 Pointer wrap: a pointer at FIFO_DEPTH-1 advances to 0, including for non-power-of-two FIFO_DEPTH.
REQ-020 Count update per cycle:
- +1 on write only.
- -1 on read only.
- Unchanged when both or neither are accepted.
REQ-021 Simultaneous rd_en and wr_en:
- When empty: only the write is accepted; underflow is asserted the next cycle.
- When full: both are accepted, so a full FIFO stays full with the oldest word replaced.
REQ-022 wr_ack:
- Next cycle = 1 if the write was accepted, else 0.
- overflow = wr_en & ~accepted.
- underflow = rd_en & ~accepted.
REQ-023 Status flags:
- full = (count==FIFO_DEPTH).
- empty = (count==0).
- almostfull = (count>=AF_LEVEL && !full).
- almostempty = (count<=AE_LEVEL && !empty).
REQ-024 FWFT=0: on an accepted read, data_out is loaded with mem[rd_ptr] at the clock edge (1-cycle latency); otherwise data_out holds its value.
REQ-025 FWFT=1: data_out = mem[rd_ptr] combinationally whenever empty=0; it shows the stored head word (0 after reset) when empty=1; rd_en acts as the pop acknowledge.
REQ-026 A rejected write or read shall not modify memory, pointers, count or data_out.

Reset
REQ-027 rst_n=0 shall asynchronously clear the following:
- wr_ptr, rd_ptr, count.
- wr_ack, overflow, underflow.
- Registered data_out (set to 0).
REQ-028 While in reset:
- empty=1; full, almostfull, almostempty=0; data_count=0.
REQ-029 Memory contents need not be cleared.
REQ-030 Reset asserted mid-transfer aborts the transfer; no write or read in that cycle takes effect.
REQ-031 Operation resumes on the first rising clk edge after rst_n returns high.

Verification
REQ-032 Fill test (defaults): write 0x0001..0x0008 on 8 consecutive cycles -> wr_ack=1 each following cycle; data_count 1..8; almostfull=1 at count 7; full=1 at count 8.
REQ-033 Overflow test: write 0xBEEF while full -> overflow=1 for one cycle, wr_ack=0, data_count stays 8, then drain returns 0x0001..0x0008 in order.
REQ-034 Underflow test: rd_en with wr_en=1 on an empty FIFO -> underflow=1, wr_ack=1, data_count=1; then rd_en with wr_en=0 on an empty FIFO -> underflow=1 and data_out unchanged.
REQ-035 Wrap and depth test: FIFO_DEPTH=6, AF_LEVEL=4, AE_LEVEL=2.
- Stream 20 words with interleaved read/write -> output order matches input order across pointer wrap.
- almostfull asserted at counts 4..5.
- almostempty asserted at counts 1..2.
REQ-036 FWFT test: FWFT=1; write 0x00A5 to an empty FIFO -> data_out=0x00A5 the cycle empty drops, with no rd_en; rd_en=1 -> empty=1 the next cycle.
REQ-037 Reset test: assert rst_n=0 mid-cycle at count 5 -> flags and data_count clear immediately without a clock edge; after release, the first write reads back correctly.
